// File: rtl/boot_run_sequencer_pkg.sv
// boot_run_sequencer shared types
// state encoding and default start address
package boot_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_DBG   = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_TRAP  = 3'd5
  } state_t;

  localparam int BOOT_BASE = 1;

endpackage

// File: rtl/boot_run_sequencer_if.sv
// boot_run_sequencer signal bundle
// master = loader/core side, slave = sequencer
interface boot_run_sequencer_if
  import boot_seq_pkg::*;
#(
  parameter int ABIT = 6,
  parameter int NBIT = 32
);

  logic            load_req;
  logic [ABIT-1:0] load_addr;
  logic [NBIT-1:0] load_data;
  logic            load_ack;
  logic            start;
  logic [ABIT-1:0] prog_len;
  logic            dbg_req;
  logic [ABIT-1:0] dbg_addr;
  logic            dbg_ack;
  logic            mem_we;
  logic [ABIT-1:0] mem_addr;
  logic [NBIT-1:0] mem_wdata;
  logic            cpu_hold;
  logic [ABIT-1:0] cpu_pc;
  logic            cpu_step;
  logic            overflow;
  logic            busy;
  logic            done;
  logic            trap;

  modport master (
    output load_req, load_addr, load_data,
    output start, prog_len,
    output dbg_req, dbg_addr,
    output overflow,
    input  load_ack, dbg_ack,
    input  mem_we, mem_addr, mem_wdata,
    input  cpu_hold, cpu_pc, cpu_step,
    input  busy, done, trap
  );

  modport slave (
    input  load_req, load_addr, load_data,
    input  start, prog_len,
    input  dbg_req, dbg_addr,
    input  overflow,
    output load_ack, dbg_ack,
    output mem_we, mem_addr, mem_wdata,
    output cpu_hold, cpu_pc, cpu_step,
    output busy, done, trap
  );

endinterface

// File: rtl/boot_run_sequencer_step_counter.sv
// loadable pc/cnt pair for the run phase
// tc flags the last instruction of the programmed length
module step_counter #(
  parameter int ABIT = 6,
  parameter int BASE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ld,
  input  logic [ABIT-1:0] i_len,
  input  logic            i_en,
  output logic [ABIT-1:0] o_pc,
  output logic            o_tc
);

  logic [ABIT-1:0] r_pc;
  logic [ABIT-1:0] r_cnt;
  logic [ABIT-1:0] r_len;

  // reload on start, advance once per issued instruction
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc  <= ABIT'(BASE);
      r_cnt <= '0;
      r_len <= '0;
    end else if (i_ld) begin
      r_pc  <= ABIT'(BASE);
      r_cnt <= '0;
      r_len <= i_len;
    end else if (i_en) begin
      r_pc  <= r_pc + ABIT'(1);
      r_cnt <= r_cnt + ABIT'(1);
    end
  end

  assign o_pc = r_pc;
  assign o_tc = (r_cnt == r_len - ABIT'(1));

endmodule

// File: rtl/boot_run_sequencer.sv
// load/run sequencer for the core
// FSM plus registered-state output decode
module boot_run_sequencer
  import boot_seq_pkg::*;
#(
  parameter int ABIT    = 6,
  parameter int NBIT    = 32,
  parameter int BASE    = BOOT_BASE,
  parameter bit TRAP_EN = 1'b1
) (
  input logic                clk,
  input logic                rst,
  boot_run_sequencer_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_WRITE = S_WRITE;
  localparam logic [2:0] ST_DBG   = S_DBG;
  localparam logic [2:0] ST_RUN   = S_RUN;
  localparam logic [2:0] ST_DONE  = S_DONE;
  localparam logic [2:0] ST_TRAP  = S_TRAP;

  logic [2:0]      r_state;
  logic [2:0]      r_ret;
  logic [2:0]      w_next;
  logic [ABIT-1:0] r_addr;
  logic [NBIT-1:0] r_data;
  logic [ABIT-1:0] w_pc;
  logic [ABIT-1:0] w_maddr;
  logic            w_ld;
  logic            w_en;
  logic            w_tc;
  logic            w_ovf;
  logic            w_wr;
  logic            w_dbg;
  logic            w_run;

  assign w_ovf = TRAP_EN & bus.overflow;

  step_counter #(
    .ABIT (ABIT),
    .BASE (BASE)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_ld  (w_ld),
    .i_len (bus.prog_len),
    .i_en  (w_en),
    .o_pc  (w_pc),
    .o_tc  (w_tc)
  );

  // next-state: load > dbg > start when parked
  always_comb begin
    w_next = r_state;
    w_ld   = 1'b0;
    w_en   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.load_req) begin
          w_next = ST_WRITE;
        end else if (bus.dbg_req) begin
          w_next = ST_DBG;
        end else if (bus.start) begin
          w_ld   = 1'b1;
          w_next = (bus.prog_len == '0)
                 ? ST_DONE : ST_RUN;
        end
      end
      ST_WRITE: w_next = ST_IDLE;
      ST_DBG:   w_next = r_ret;
      ST_RUN: begin
        if (w_ovf) begin
          w_next = ST_TRAP;
        end else begin
          w_en = 1'b1;
          if (w_tc) w_next = ST_DONE;
        end
      end
      ST_TRAP:  w_next = ST_TRAP;
      default:  w_next = ST_IDLE;
    endcase
  end

  // state register; trap only leaves through reset
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // capture write/debug operands so outputs stay registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ret  <= ST_IDLE;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      if (w_next == ST_WRITE) begin
        r_addr <= bus.load_addr;
        r_data <= bus.load_data;
      end
      if (w_next == ST_DBG) begin
        r_addr <= bus.dbg_addr;
        r_ret  <= r_state;
      end
    end
  end

  assign w_wr  = (r_state == ST_WRITE);
  assign w_dbg = (r_state == ST_DBG);
  assign w_run = (r_state == ST_RUN);

  // memory address mux by phase
  always_comb begin
    w_maddr = '0;
    unique case (1'b1)
      w_wr, w_dbg: w_maddr = r_addr;
      w_run:       w_maddr = w_pc;
      default:     w_maddr = '0;
    endcase
  end

  assign bus.load_ack  = w_wr;
  assign bus.mem_we    = w_wr;
  assign bus.dbg_ack   = w_dbg;
  assign bus.mem_addr  = w_maddr;
  assign bus.mem_wdata = w_wr ? r_data : '0;
  assign bus.cpu_step  = w_run;
  assign bus.cpu_hold  = ~w_run;
  assign bus.cpu_pc    = w_pc;
  assign bus.busy      = w_wr | w_run;
  assign bus.done      = (r_state == ST_DONE);
  assign bus.trap      = (r_state == ST_TRAP);

endmodule

// File: doc/boot_run_sequencer.md
# boot_run_sequencer

Control block that sequences the MIPS processor core through its two operating phases. In the load phase it arbitrates instruction-memory write access for an external loader (DMA) with a req/ack handshake. In the run phase it holds the core's PC, issues one instruction per cycle over a programmed length, and stops on completion or on an arithmetic-overflow trap. It sits between the loader/testbench side and the processor's instruction memory and fetch port, and also provides a debug read port into instruction memory.

## Interface
Parameters:
- ABIT, 6, instruction-memory address width
- NBIT, 32, instruction word width
- BASE, 1, first instruction address executed in RUN
- TRAP_EN, 1, 1 = overflow during RUN enters TRAP

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- load_req  in  1  loader requests one word write
- load_addr  in  ABIT  write address
- load_data  in  NBIT  write data
- load_ack  out  1  one-cycle pulse: word written
- start  in  1  begin execution (level, sampled in IDLE/DONE)
- prog_len  in  ABIT  number of instructions to execute, sampled with start
- dbg_req  in  1  debug read request
- dbg_addr  in  ABIT  debug read address
- dbg_ack  out  1  one-cycle pulse: mem_rdata valid for debug
- mem_we  out  1  instruction-memory write enable
- mem_addr  out  ABIT  instruction-memory address
- mem_wdata  out  NBIT  instruction-memory write data
- cpu_hold  out  1  1 = core stalled
- cpu_pc  out  ABIT  address of instruction issued this cycle
- cpu_step  out  1  1 = core executes cpu_pc this cycle
- overflow  in  1  core ALU overflow flag
- busy  out  1  state is WRITE or RUN
- done  out  1  state is DONE
- trap  out  1  state is TRAP

## Operation
- States: IDLE, WRITE, DBG, RUN, DONE, TRAP.
- IDLE:
  - load_req → WRITE.
  - else dbg_req → DBG.
  - else start → RUN, latching len = prog_len and setting pc = BASE.
  - Priority is load > dbg > start; lower-priority requests wait.
  - If start is sampled with prog_len = 0, go directly to DONE.
- WRITE (1 cycle): mem_we = 1, mem_addr = load_addr, mem_wdata = load_data, load_ack = 1; then → IDLE.
  - The loader holds req/addr/data stable until it sees ack.
  - A word is never written twice for one ack; maximum throughput is 1 word per 2 cycles.
- DBG (1 cycle): mem_addr = dbg_addr, dbg_ack = 1; mem_rdata is valid this cycle. Then return to the state DBG was entered from (IDLE or DONE).
- RUN: cpu_hold = 0, cpu_step = 1, cpu_pc = pc, mem_addr = pc.
  - cnt increments every cycle.
  - When cnt = len-1, the next state is DONE.
  - pc wraps modulo 2^ABIT.
  - load_req and dbg_req are ignored (not acked) while in RUN.
- Trap: if overflow = 1 in RUN and TRAP_EN = 1 → TRAP.
  - The instruction that raised overflow counts as executed.
  - Overflow wins over the final-count transition to DONE in the same cycle.
- DONE: cpu_hold = 1.
  - dbg_req → DBG.
  - start → RUN again, reloading len and pc.
  - load_req → WRITE, allowing reprogramming.
- TRAP: cpu_hold = 1, trap = 1, cpu_pc frozen at the faulting address. Exit only via rst.
- Reset: rst = 0 at any edge → IDLE regardless of state, including mid-WRITE (ack not issued) and mid-RUN.

## Timing
- Reset values: load_ack = 0, dbg_ack = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_hold = 1, cpu_pc = BASE, cpu_step = 0, busy = 0, done = 0, trap = 0.
- All outputs are registered or decoded from the registered state; there are no comb paths from inputs to outputs.
- load_req sampled at edge N → mem_we and load_ack high for cycle N+1.
- start sampled at edge N → first cpu_step in cycle N+1 with cpu_pc = BASE.
  - The last cpu_step is in cycle N+len.
  - done goes high in cycle N+len+1.
- dbg latency: 1 cycle request-to-ack.
- overflow is sampled at the same edge as the step it belongs to.

## Structure
- Package boot_seq_pkg: state enum (state_t, 3 bits) and the default BASE constant.
- Sub-module step_counter: loadable pc/cnt pair with a terminal-count flag.
- Top module: FSM and output mux.

## Test plan
- Load words to addr 1..16 with back-to-back req → exactly 16 load_ack pulses, each 2 cycles apart, with mem_we coincident and mem_addr/mem_wdata matching.
- start with prog_len = 16 → cpu_step for 16 consecutive cycles, cpu_pc = 1..16, then done = 1 and cpu_hold = 1.
- start with prog_len = 0 → DONE next cycle, no cpu_step.
- overflow pulse at pc = 7 → TRAP, trap = 1, cpu_pc stays 7; load_req not acked until rst.
- load_req and start asserted together in IDLE → WRITE first, RUN begins two cycles later.
- rst low during RUN at pc = 5 → next cycle IDLE with all outputs at reset values; dbg read in DONE of addr 3 → dbg_ack 1 cycle later.
